// File: rtl/fft_sdf_stage_ctrl_pkg.sv
// Shared types and constants for the radix-2 SDF FFT stage controller.
package fft_pkg;

  localparam int FLOAT_LEN = 32;
  localparam int CPLX_W    = 2 * FLOAT_LEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Words held in the delay FIFO of a given stage.
  function automatic int delay_f(input int n_log2, input int stage);
    return 1 << (n_log2 - stage);
  endfunction

endpackage

// File: rtl/fft_sdf_stage_ctrl_if.sv
// Control bundle between an SDF stage sequencer and its FIFO / butterfly / twiddle ROM.
interface fft_sdf_stage_ctrl_if #(
  parameter int N_LOG2 = 13
);
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic              bf_sel;
  logic              tf_rd_en;
  logic [N_LOG2-2:0] tf_addr;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              err;

  modport master (
    output in_valid, in_last, fifo_full, fifo_empty,
    input  in_ready, fifo_wr_en, fifo_rd_en, bf_sel, tf_rd_en, tf_addr,
           out_valid, out_last, busy, err
  );

  modport slave (
    input  in_valid, in_last, fifo_full, fifo_empty,
    output in_ready, fifo_wr_en, fifo_rd_en, bf_sel, tf_rd_en, tf_addr,
           out_valid, out_last, busy, err
  );
endinterface

// File: rtl/fft_sdf_stage_ctrl_valid_dly.sv
// Fixed-depth shift pipeline aligning out_valid/out_last with butterfly latency.
module fft_valid_dly #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: FIFO strobes, butterfly select, twiddle address.
// Optional sticky protocol-error checking is built when FFT_CTRL_ERRCHK_EN is defined.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 13,
  parameter int STAGE  = 1,
  parameter int BF_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fft_sdf_stage_ctrl_if.slave  io_ctrl
);
  localparam int DELAY = delay_f(N_LOG2, STAGE);
  localparam int CW    = N_LOG2 - STAGE + 1;
  localparam int TW    = N_LOG2 - 1;
  localparam logic [CW-1:0] C_DLY  = CW'(DELAY);
  localparam logic [CW-1:0] C_D_M1 = CW'(DELAY - 1);
  localparam logic [CW-1:0] C_LAST = CW'(2 * DELAY - 1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_off;
  logic            r_pend, w_pend_nxt;
  logic            w_in_ready, w_accept, w_hi;
  logic            w_wr_en, w_rd_en, w_bf_sel, w_tf_rd_en, w_flush_last;
  logic [TW-1:0]   w_tf_addr;
  logic [1:0]      w_vq;

  assign w_in_ready = (r_state != FLUSH);
  // Samples presented while reset is asserted are never taken.
  assign w_accept   = io_ctrl.in_valid & w_in_ready & ~i_rst;
  assign w_hi       = (r_cnt >= C_DLY);
  assign w_cnt_off  = r_cnt - C_DLY;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_bf_sel     = 1'b0;
    w_tf_rd_en   = 1'b0;
    w_tf_addr    = '0;
    w_flush_last = 1'b0;
    case (r_state)
      FLUSH: begin
        w_rd_en   = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_D_M1) begin
          w_flush_last = 1'b1;
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_pend_nxt   = 1'b0;
        end
      end
      default: begin
        if (w_accept) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_hi) begin
            w_rd_en    = 1'b1;
            w_bf_sel   = 1'b1;
            w_tf_rd_en = 1'b1;
            w_tf_addr  = TW'(w_cnt_off) << (STAGE - 1);
          end else begin
            // Fill of a later frame drains the previous frame's differences.
            w_rd_en = r_pend;
          end
          if (r_cnt == C_D_M1) begin
            w_state_nxt = BFLY;
          end else if (r_cnt == C_LAST) begin
            w_pend_nxt  = 1'b1;
            w_state_nxt = io_ctrl.in_last ? FLUSH : FILL;
          end else if (r_state == IDLE) begin
            w_state_nxt = FILL;
          end
        end
      end
    endcase
  end

  // Every FIFO read yields one stage output word once the butterfly settles.
  fft_valid_dly #(.DEPTH(BF_LAT + 1), .WIDTH(2)) u_vdly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({w_flush_last, w_rd_en}),
    .o_q   (w_vq)
  );

  assign io_ctrl.in_ready   = w_in_ready;
  assign io_ctrl.fifo_wr_en = w_wr_en;
  assign io_ctrl.fifo_rd_en = w_rd_en;
  assign io_ctrl.bf_sel     = w_bf_sel;
  assign io_ctrl.tf_rd_en   = w_tf_rd_en;
  assign io_ctrl.tf_addr    = w_tf_addr;
  assign io_ctrl.out_valid  = w_vq[0];
  assign io_ctrl.out_last   = w_vq[1];
  assign io_ctrl.busy       = (r_state != IDLE);

`ifdef FFT_CTRL_ERRCHK_EN
  logic r_err;
  logic w_last_misplaced;

  assign w_last_misplaced = w_accept & io_ctrl.in_last & (r_cnt != C_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if ((w_wr_en & io_ctrl.fifo_full) | (w_rd_en & io_ctrl.fifo_empty) |
                 w_last_misplaced) begin
      r_err <= 1'b1;
    end
  end

  assign io_ctrl.err = r_err;
`else
  assign io_ctrl.err = 1'b0;
`endif
endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Bench for fft_sdf_stage_ctrl: stage 1 (DELAY 4) and stage 2 (DELAY 2) of an 8-point FFT.
`timescale 1ns/1ps
module tb_fft_sdf_stage_ctrl;
  localparam int N_LOG2 = 3;
`ifdef FFT_CTRL_ERRCHK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b0;
  always #5 clk = ~clk;

  fft_sdf_stage_ctrl_if #(.N_LOG2(N_LOG2)) if0 ();
  fft_sdf_stage_ctrl_if #(.N_LOG2(N_LOG2)) if1 ();

  assign if0.in_valid = in_valid;   assign if1.in_valid = in_valid;
  assign if0.in_last = in_last;     assign if1.in_last = in_last;
  assign if0.fifo_full = fifo_full; assign if1.fifo_full = fifo_full;
  assign if0.fifo_empty = fifo_empty; assign if1.fifo_empty = fifo_empty;

  fft_sdf_stage_ctrl #(.N_LOG2(N_LOG2), .STAGE(1), .BF_LAT(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .io_ctrl(if0));
  fft_sdf_stage_ctrl #(.N_LOG2(N_LOG2), .STAGE(2), .BF_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .io_ctrl(if1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int in_ready, wr, rd, bf, tfr, tfa, ov, ol, busy, err;
  } obs_t;

  function automatic obs_t get_obs(input int i);
    obs_t o;
    if (i == 0) begin
      o.in_ready = int'(if0.in_ready); o.wr = int'(if0.fifo_wr_en); o.rd = int'(if0.fifo_rd_en);
      o.bf = int'(if0.bf_sel); o.tfr = int'(if0.tf_rd_en); o.tfa = int'(if0.tf_addr);
      o.ov = int'(if0.out_valid); o.ol = int'(if0.out_last); o.busy = int'(if0.busy);
      o.err = int'(if0.err);
    end else begin
      o.in_ready = int'(if1.in_ready); o.wr = int'(if1.fifo_wr_en); o.rd = int'(if1.fifo_rd_en);
      o.bf = int'(if1.bf_sel); o.tfr = int'(if1.tf_rd_en); o.tfa = int'(if1.tf_addr);
      o.ov = int'(if1.out_valid); o.ol = int'(if1.out_last); o.busy = int'(if1.busy);
      o.err = int'(if1.err);
    end
    return o;
  endfunction

  // Model: sample index within the run, flush countdown, output events scheduled 2 cycles ahead.
  int  dly[2] = '{4, 2};
  int  stg[2] = '{1, 2};
  int  m_k[2], m_fl[2];
  bit  m_err[2];
  bit  ev[2][8], el[2][8];
  int  cyc = 0;
  bit  started = 1'b0;
  int  ov_cnt[2], ol_cnt[2];
  int  tfq0[$], tfq1[$];

  always @(negedge clk) begin
    obs_t a, e;
    int pos;
    bit hi, src_v, src_l;
    if (rst) begin
      started = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_k[i] = 0; m_fl[i] = 0; m_err[i] = 1'b0;
        for (int s = 0; s < 8; s++) begin ev[i][s] = 1'b0; el[i][s] = 1'b0; end
      end
    end else if (started) begin
      for (int i = 0; i < 2; i++) begin
        a = get_obs(i);
        e = '{default: 0};
        e.busy = (m_k[i] > 0 || m_fl[i] > 0) ? 1 : 0;
        e.in_ready = (m_fl[i] == 0) ? 1 : 0;
        e.ov = int'(ev[i][cyc % 8]); e.ol = int'(el[i][cyc % 8]);
        ev[i][cyc % 8] = 1'b0; el[i][cyc % 8] = 1'b0;
        e.err = int'(m_err[i]);
        src_v = 1'b0; src_l = 1'b0;
        if (m_fl[i] > 0) begin
          e.rd = 1; src_v = 1'b1; src_l = (m_fl[i] == 1);
          m_fl[i]--;
          if (m_fl[i] == 0) m_k[i] = 0;
        end else if (in_valid) begin
          pos = m_k[i] % (2 * dly[i]);
          hi  = (pos >= dly[i]);
          e.wr = 1; e.bf = int'(hi); e.tfr = int'(hi);
          e.rd = (hi || m_k[i] >= 2 * dly[i]) ? 1 : 0;
          e.tfa = hi ? ((pos - dly[i]) << (stg[i] - 1)) : 0;
          src_v = (e.rd == 1);
          if (in_last && pos == 2 * dly[i] - 1) m_fl[i] = dly[i];
`ifdef FFT_CTRL_ERRCHK_EN
          if (in_last && pos != 2 * dly[i] - 1) m_err[i] = 1'b1;
`endif
          m_k[i]++;
        end
`ifdef FFT_CTRL_ERRCHK_EN
        if ((e.wr == 1 && fifo_full) || (e.rd == 1 && fifo_empty)) m_err[i] = 1'b1;
`endif
        ev[i][(cyc + 2) % 8] = src_v; el[i][(cyc + 2) % 8] = src_l;
        chk($sformatf("d%0d_in_ready c%0d", i, cyc), a.in_ready, e.in_ready);
        chk($sformatf("d%0d_wr_en c%0d", i, cyc), a.wr, e.wr);
        chk($sformatf("d%0d_rd_en c%0d", i, cyc), a.rd, e.rd);
        chk($sformatf("d%0d_bf_sel c%0d", i, cyc), a.bf, e.bf);
        chk($sformatf("d%0d_tf_rd_en c%0d", i, cyc), a.tfr, e.tfr);
        chk($sformatf("d%0d_tf_addr c%0d", i, cyc), a.tfa, e.tfa);
        chk($sformatf("d%0d_out_valid c%0d", i, cyc), a.ov, e.ov);
        chk($sformatf("d%0d_out_last c%0d", i, cyc), a.ol, e.ol);
        chk($sformatf("d%0d_busy c%0d", i, cyc), a.busy, e.busy);
        chk($sformatf("d%0d_err c%0d", i, cyc), a.err, e.err);
        if (a.ov == 1) ov_cnt[i]++;
        if (a.ol == 1) ol_cnt[i]++;
        if (a.tfr == 1) begin
          if (i == 0) tfq0.push_back(a.tfa); else tfq1.push_back(a.tfa);
        end
      end
    end
    cyc++;
  end

  task automatic drive(input bit r, input bit v, input bit l, input bit ff);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_last = l; fifo_full = ff;
    #2;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    ov_cnt = '{0, 0}; ol_cnt = '{0, 0};
    tfq0.delete(); tfq1.delete();
  endtask

  task automatic chk_q(input string name, input int q[$], input int e0, input int e1,
                       input int e2, input int e3);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    chk({name, "_len"}, q.size(), 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s[%0d]", name, j), (j < q.size()) ? q[j] : -1, exp[j]);
  endtask

  initial begin
    repeat (2) do_reset();
    // Test 1: 8 continuous samples, no last.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 1) begin
        chk("t1_wr_s1", int'(if0.fifo_wr_en), 1);
        chk("t1_rd_s1", int'(if0.fifo_rd_en), 0);
      end
      if (k >= 5) begin
        chk($sformatf("t1_tf_addr_s%0d", k), int'(if0.tf_addr), k - 5);
        chk($sformatf("t1_bf_sel_s%0d", k), int'(if0.bf_sel), 1);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (j == 2) chk("t1_out_valid_c10", int'(if0.out_valid), 1);
      if (j == 3) chk("t1_out_valid_c11", int'(if0.out_valid), 0);
    end
    chk("t1_ov_count", ov_cnt[0], 4);
    chk_q("t1_tfq_s1", tfq0, 0, 1, 2, 3);
    chk_q("t6_tfq_s2", tfq1, 0, 2, 0, 2);

    // Test 2: two frames, last on the 16th sample, then flush.
    do_reset();
    for (int k = 1; k <= 16; k++) drive(1'b0, 1'b1, (k == 16), 1'b0);
    for (int j = 1; j <= 8; j++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (j == 1) chk("t2_in_ready_flush", int'(if0.in_ready), 0);
      if (j == 4) chk("t2_rd_flush_end", int'(if0.fifo_rd_en), 1);
    end
    chk("t2_ov_count", ov_cnt[0], 16);
    chk("t2_ol_count", ol_cnt[0], 1);
    chk("t2_busy_end", int'(if0.busy), 0);

    // Test 3: a gap every third cycle.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, (k % 3 != 2), 1'b0, 1'b0);
      if (k == 2) chk("t3_wr_gap", int'(if0.fifo_wr_en), 0);
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_q("t3_tfq_s1", tfq0, 0, 1, 2, 3);
    chk_q("t3_tfq_s2", tfq1, 0, 2, 0, 2);

    // Test 4: reset on sample 6.
    do_reset();
    for (int k = 1; k <= 5; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_in_ready", int'(if0.in_ready), 1);
    chk("t4_busy", int'(if0.busy), 0);
    chk("t4_out_valid", int'(if0.out_valid), 0);
    chk("t4_tf_addr", int'(if0.tf_addr), 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Test 5: FIFO full during fill, then misplaced last.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_err_full", int'(if0.err), ERR_EXP);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_err_sticky", int'(if0.err), ERR_EXP);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_err_cleared", int'(if0.err), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_err_last", int'(if0.err), ERR_EXP);
    chk("t5_no_flush", int'(if0.in_ready), 1);
    chk("t5_busy", int'(if0.busy), 1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
